// File: rtl/ufp_mem_rsp.sv
// ufp memory responder: word-addressed SRAM model with fixed programmable latency, one outstanding request.
// Optional UFP_MEM_ERR_EN adds the ufp_err port plus range and mask-legality checking.
module ufp_mem_rsp #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1eceb000,
  parameter int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ufp_addr,
  input  logic [3:0]  ufp_rmask,
  input  logic [3:0]  ufp_wmask,
  input  logic [31:0] ufp_wdata,
  output logic [31:0] ufp_rdata,
`ifdef UFP_MEM_ERR_EN
  output logic        ufp_err,
`endif
  output logic        ufp_resp
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0]       mem_q [DEPTH_WORDS];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              resp_q, resp_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        rmask_q, rmask_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       offset_s;
  logic              req_s;
  logic              accept_s;
  logic              err_s;
  logic [31:0]       rdata_s;

`ifdef UFP_MEM_ERR_EN
  logic              err_q, err_d;

  function automatic logic mask_legal(input logic [3:0] m);
    logic ok;
    case (m)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  assign offset_s = ufp_addr - BASE_ADDR;
  assign req_s    = (ufp_rmask != 4'b0000) || (ufp_wmask != 4'b0000);
  // The resp cycle of the previous request doubles as an accept slot.
  assign accept_s = (state_q == IDLE) || resp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
`ifdef UFP_MEM_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      BUSY: begin
        if (resp_q) begin
          if (req_s) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (accept_s && req_s) begin
      idx_d   = ADDR_W'(offset_s >> 2);
      rmask_d = ufp_rmask;
      wmask_d = ufp_wmask;
      wdata_d = ufp_wdata;
`ifdef UFP_MEM_ERR_EN
      err_d   = ((offset_s >> 2) >= 32'(DEPTH_WORDS)) ||
                !mask_legal(ufp_rmask) || !mask_legal(ufp_wmask);
`endif
    end

    resp_d = (state_d == BUSY) && (cnt_d == 4'd0);
  end

  // Control and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= 1'b0;
      idx_q   <= '0;
      rmask_q <= 4'b0000;
      wmask_q <= 4'b0000;
      wdata_q <= 32'h0000_0000;
`ifdef UFP_MEM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      idx_q   <= idx_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
`ifdef UFP_MEM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

`ifdef UFP_MEM_ERR_EN
  assign err_s   = err_q;
  assign ufp_err = resp_q && err_q;
`else
  assign err_s   = 1'b0;
`endif

  // Write commits at the edge closing the resp cycle, so the read side sees pre-write data.
  always_ff @(posedge clk) begin
    if (!rst && resp_q && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) begin
          mem_q[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata_s = 32'h0000_0000;
    if (resp_q && !err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (rmask_q[i]) begin
          rdata_s[i*8 +: 8] = mem_q[idx_q][i*8 +: 8];
        end else begin
          rdata_s[i*8 +: 8] = 8'h00;
        end
      end
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign ufp_rdata = rdata_s;
  assign ufp_resp  = resp_q;

endmodule

// File: tb/tb_ufp_mem_rsp.sv
// Directed bench for ufp_mem_rsp: three instances at LATENCY 2, 1 and 3 sharing one clock and reset.
module tb_ufp_mem_rsp;

  localparam logic [31:0] BASE = 32'h1eceb000;

  logic        clk;
  logic        rst;
  logic [31:0] addr_s  [3];
  logic [3:0]  rmask_s [3];
  logic [3:0]  wmask_s [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        resp_s  [3];
  logic        err_s   [3];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ufp_mem_rsp #(
      .DEPTH_WORDS(1024),
      .LATENCY    (g == 0 ? 2 : (g == 1 ? 1 : 3)),
      .BASE_ADDR  (32'h1eceb000)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .ufp_addr (addr_s[g]),
      .ufp_rmask(rmask_s[g]),
      .ufp_wmask(wmask_s[g]),
      .ufp_wdata(wdata_s[g]),
      .ufp_rdata(rdata_s[g]),
`ifdef UFP_MEM_ERR_EN
      .ufp_err  (err_s[g]),
`endif
      .ufp_resp (resp_s[g])
    );
`ifndef UFP_MEM_ERR_EN
    assign err_s[g] = 1'b0;
`endif
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
    addr_s[d]  = a;
    rmask_s[d] = rm;
    wmask_s[d] = wm;
    wdata_s[d] = wd;
  endtask

  task automatic idle(input int d);
    drive(d, 32'h0000_0000, 4'b0000, 4'b0000, 32'h0000_0000);
  endtask

  // One isolated transaction: checks silence before, the pulse at exactly T+LATENCY, and silence after.
  task automatic xact(input int d, input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] wd, input logic [31:0] exp, input logic exp_err, input string tag);
    @(negedge clk);
    drive(d, a, rm, wm, wd);
    for (int k = 1; k <= lat(d); k++) begin
      @(negedge clk);
      if (k == 1) idle(d);
      if (k < lat(d)) begin
        check_eq({tag, "_early"}, {31'd0, resp_s[d]}, 32'd0);
      end else begin
        check_eq({tag, "_resp"}, {31'd0, resp_s[d]}, 32'd1);
        check_eq({tag, "_rdata"}, rdata_s[d], exp);
`ifdef UFP_MEM_ERR_EN
        check_eq({tag, "_err"}, {31'd0, err_s[d]}, {31'd0, exp_err});
`else
        if (exp_err) check_eq({tag, "_err_cfg"}, {31'd0, err_s[d]}, 32'd1);
`endif
      end
    end
    @(negedge clk);
    check_eq({tag, "_after"}, {31'd0, resp_s[d]}, 32'd0);
    check_eq({tag, "_rdata0"}, rdata_s[d], 32'd0);
  endtask

  initial begin
    logic [31:0] burst_val [8];
    rst = 1'b1;
    for (int d = 0; d < 3; d++) idle(d);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("reset_resp%0d", d), {31'd0, resp_s[d]}, 32'd0);
      check_eq($sformatf("reset_rdata%0d", d), rdata_s[d], 32'd0);
      check_eq($sformatf("reset_err%0d", d), {31'd0, err_s[d]}, 32'd0);
    end
    rst = 1'b0;

    // Preload LATENCY=2 instance, then basic read and lane masks.
    xact(0, BASE,        4'h0, 4'hf, 32'hdeadbeef, 32'd0, 1'b0, "pre_w0");
    xact(0, BASE + 32'd4, 4'h0, 4'hf, 32'h0000_0000, 32'd0, 1'b0, "pre_w1");
    xact(0, BASE,        4'hf, 4'h0, 32'd0, 32'hdeadbeef, 1'b0, "rd_w0");
    xact(0, BASE,        4'b1100, 4'h0, 32'd0, 32'hdead0000, 1'b0, "rd_hi");
    xact(0, BASE,        4'b0001, 4'h0, 32'd0, 32'h000000ef, 1'b0, "rd_b0");

    // Partial write, with a read of the same word accepted in the write's resp cycle.
    @(negedge clk);
    drive(0, BASE + 32'd4, 4'h0, 4'b0011, 32'h1234abcd);
    @(negedge clk);
    idle(0);
    check_eq("b2b_early", {31'd0, resp_s[0]}, 32'd0);
    @(negedge clk);
    check_eq("b2b_wresp", {31'd0, resp_s[0]}, 32'd1);
    drive(0, BASE + 32'd4, 4'hf, 4'h0, 32'd0);
    @(negedge clk);
    idle(0);
    check_eq("b2b_gap", {31'd0, resp_s[0]}, 32'd0);
    @(negedge clk);
    check_eq("b2b_rresp", {31'd0, resp_s[0]}, 32'd1);
    check_eq("b2b_rdata", rdata_s[0], 32'h0000abcd);

    // Read-before-write on a combined request.
    xact(0, BASE + 32'd12, 4'h0, 4'hf, 32'h01020304, 32'd0, 1'b0, "pre_w3");
    xact(0, BASE + 32'd12, 4'hf, 4'b1010, 32'haabbccdd, 32'h01020304, 1'b0, "rbw_old");
    xact(0, BASE + 32'd12, 4'hf, 4'h0, 32'd0, 32'haa02cc04, 1'b0, "rbw_new");

    // Reset one cycle after a write request: write dropped, no resp.
    xact(0, BASE + 32'd8, 4'h0, 4'hf, 32'h55aa55aa, 32'd0, 1'b0, "pre_w2");
    @(negedge clk);
    drive(0, BASE + 32'd8, 4'h0, 4'hf, 32'hffffffff);
    @(negedge clk);
    idle(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rst_noresp%0d", k), {31'd0, resp_s[0]}, 32'd0);
      @(negedge clk);
    end
    xact(0, BASE + 32'd8, 4'hf, 4'h0, 32'd0, 32'h55aa55aa, 1'b0, "rst_keep");

`ifdef UFP_MEM_ERR_EN
    xact(0, BASE + 32'd4096, 4'hf, 4'h0, 32'd0, 32'd0, 1'b1, "err_range");
    xact(0, BASE, 4'h0, 4'b0110, 32'h11111111, 32'd0, 1'b1, "err_mask");
    xact(0, BASE, 4'hf, 4'h0, 32'd0, 32'hdeadbeef, 1'b0, "err_nowr");
`else
    xact(0, BASE + 32'd4096, 4'hf, 4'h0, 32'd0, 32'hdeadbeef, 1'b0, "wrap_w0");
`endif

    // LATENCY=1: eight back-to-back reads, one pulse per cycle.
    for (int i = 0; i < 8; i++) begin
      burst_val[i] = 32'h1357_9bdf ^ (32'h0101_0101 * i);
      xact(1, BASE + 32'(4 * i), 4'h0, 4'hf, burst_val[i], 32'd0, 1'b0, "pre_b");
    end
    @(negedge clk);
    drive(1, BASE, 4'hf, 4'h0, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("burst_resp%0d", i - 1), {31'd0, resp_s[1]}, 32'd1);
      check_eq($sformatf("burst_rdata%0d", i - 1), rdata_s[1], burst_val[i - 1]);
      if (i < 8) drive(1, BASE + 32'(4 * i), 4'hf, 4'h0, 32'd0);
      else idle(1);
    end
    @(negedge clk);
    check_eq("burst_end", {31'd0, resp_s[1]}, 32'd0);

    // LATENCY=3: request during BUSY is dropped.
    xact(2, BASE, 4'h0, 4'hf, 32'hdeadbeef, 32'd0, 1'b0, "pre_l3");
    @(negedge clk);
    drive(2, BASE, 4'hf, 4'h0, 32'd0);
    @(negedge clk);
    drive(2, BASE + 32'd4, 4'hf, 4'h0, 32'd0);
    @(negedge clk);
    idle(2);
    check_eq("l3_early", {31'd0, resp_s[2]}, 32'd0);
    @(negedge clk);
    check_eq("l3_resp", {31'd0, resp_s[2]}, 32'd1);
    check_eq("l3_rdata", rdata_s[2], 32'hdeadbeef);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("l3_ignored%0d", k), {31'd0, resp_s[2]}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
